mod_n_updown_counter: RTL and testbench

Parametrised, cascadable multi-digit modulo-N up/down counter. It replaces the fixed 4-bit decade counter with a configurable radix and digit count, plus up/down counting, synchronous clear and load, a terminal-count output for cascading, and a sticky wrap flag. It sits in the timer/display datapath and feeds digit decoders directly; one digit field per display digit.

---
 rtl/mod_n_updown_counter.sv | 119 +++++++++++
 tb/tb_mod_n_updown_counter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_n_updown_counter.sv
// mod_n_updown_counter
//
// Cascadable multi-digit modulo-MOD up/down counter. Every digit counts
// 0..MOD-1; digit 0 is least significant. Intended to feed per-digit display
// decoders directly and to chain into further counters through tc.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-high reset (count, wrap, load_err -> 0)
//   en        count enable
//   up        direction: 1 = increment, 0 = decrement
//   clr       synchronous clear of count and wrap (beats load and en)
//   load      synchronous parallel load (beats en); digits >= MOD clamp to MOD-1
//   load_val  load value, digit i at [i*DW +: DW]
//   count     current value, digit i at [i*DW +: DW]
//   tc        combinational terminal count: high in the cycle whose edge
//             performs a full-range wrap
//   wrap      sticky full-range wrap flag, cleared only by clr or rst
//   load_err  one-cycle registered pulse after a load that clamped a digit
//
// Control semantics: clr, load and en are level requests sampled on each
// rising edge; there is no handshake and no back-pressure, so every sampled
// request takes effect on that edge with priority rst > clr > load > en.

module mod_n_updown_counter #(
  parameter int MOD    = 10,
  parameter int DIGITS = 2,
  parameter int DW     = $clog2(MOD)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 up,
  input  logic                 clr,
  input  logic                 load,
  input  logic [DIGITS*DW-1:0] load_val,
  output logic [DIGITS*DW-1:0] count,
  output logic                 tc,
  output logic                 wrap,
  output logic                 load_err
);

  localparam logic [DW-1:0] MAX_DIGIT = DW'(MOD - 1);

  logic [DIGITS-1:0]    at_max;
  logic [DIGITS-1:0]    at_zero;
  logic [DIGITS-1:0]    over;
  logic [DIGITS:0]      ripple_up;
  logic [DIGITS:0]      ripple_dn;
  logic [DIGITS*DW-1:0] step_val;
  logic [DIGITS*DW-1:0] load_fix;
  logic                 full_up;
  logic                 full_dn;

  // Ripple enables: digit i moves only when every lower digit sits at the
  // boundary for the current direction. Bit DIGITS means "all digits at the
  // boundary", i.e. the next step is a full-range wrap.
  always_comb begin
    ripple_up[0] = 1'b1;
    ripple_dn[0] = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      ripple_up[i+1] = ripple_up[i] & at_max[i];
      ripple_dn[i+1] = ripple_dn[i] & at_zero[i];
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [DW-1:0] cur;
    logic [DW-1:0] ld;
    logic [DW-1:0] nxt;

    assign cur        = count[i*DW +: DW];
    assign ld         = load_val[i*DW +: DW];
    assign at_max[i]  = (cur == MAX_DIGIT);
    assign at_zero[i] = (cur == '0);

    always_comb begin
      nxt = cur;
      if (up) begin
        if (ripple_up[i]) nxt = at_max[i] ? '0 : cur + DW'(1);
      end else begin
        if (ripple_dn[i]) nxt = at_zero[i] ? MAX_DIGIT : cur - DW'(1);
      end
    end

    assign step_val[i*DW +: DW] = nxt;

    // Out-of-range load digits clamp to the top legal value so a digit can
    // never hold MOD..2**DW-1.
    assign over[i]              = (ld > MAX_DIGIT);
    assign load_fix[i*DW +: DW] = over[i] ? MAX_DIGIT : ld;
  end

  assign full_up = ripple_up[DIGITS];
  assign full_dn = ripple_dn[DIGITS];
  assign tc      = en & (up ? full_up : full_dn);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      load_err <= 1'b0;
      if (clr) begin
        count <= '0;
        wrap  <= 1'b0;
      end else if (load) begin
        count    <= load_fix;
        load_err <= |over;
      end else if (en) begin
        count <= step_val;
        // tc already encodes en and "all digits at the boundary".
        if (tc) wrap <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Bench for mod_n_updown_counter: a BCD instance (MOD=10, DIGITS=2) and a
// hex instance (MOD=16, DIGITS=3) share all control inputs. The reference
// model keeps each counter as a plain integer modulo MOD**DIGITS and converts
// to digit fields only when forming the expected response.

module tb_mod_n_updown_counter;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        up;
  logic        clr;
  logic        load;
  logic [7:0]  load_val_a;
  logic [7:0]  count_a;
  logic        tc_a;
  logic        wrap_a;
  logic        load_err_a;
  logic [11:0] load_val_b;
  logic [11:0] count_b;
  logic        tc_b;
  logic        wrap_b;
  logic        load_err_b;

  always #5 clk = ~clk;

  mod_n_updown_counter #(.MOD(10), .DIGITS(2)) u_dut_a (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val_a), .count(count_a), .tc(tc_a), .wrap(wrap_a),
    .load_err(load_err_a)
  );

  mod_n_updown_counter #(.MOD(16), .DIGITS(3)) u_dut_b (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val_b), .count(count_b), .tc(tc_b), .wrap(wrap_b),
    .load_err(load_err_b)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  // {tc_b, load_err_b, wrap_b, count_b[11:0], tc_a, load_err_a, wrap_a, count_a[7:0]}
  logic [25:0] exp_q[$];
  logic [25:0] mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int mod_p[2]   = '{10, 16};
  int dig_p[2]   = '{2, 3};
  int dw_p[2]    = '{4, 4};
  int range_p[2] = '{100, 4096};
  int mv[2];
  bit mw[2];
  bit ml[2];

  function automatic int load_value(input logic [31:0] f, input int k, output bit err);
    int v = 0;
    int w = 1;
    int d;
    err = 1'b0;
    for (int i = 0; i < dig_p[k]; i++) begin
      d = int'((f >> (i * dw_p[k])) & ((32'd1 << dw_p[k]) - 32'd1));
      if (d >= mod_p[k]) begin
        d   = mod_p[k] - 1;
        err = 1'b1;
      end
      v = v + d * w;
      w = w * mod_p[k];
    end
    return v;
  endfunction

  function automatic logic [31:0] to_field(input int v, input int k);
    logic [31:0] f = '0;
    int r = v;
    for (int i = 0; i < dig_p[k]; i++) begin
      f = f | (32'(r % mod_p[k]) << (i * dw_p[k]));
      r = r / mod_p[k];
    end
    return f;
  endfunction

  function automatic bit model_tc(input int k);
    return en && (up ? (mv[k] == range_p[k] - 1) : (mv[k] == 0));
  endfunction

  task automatic model_edge();
    logic [31:0] lv;
    bit e;
    for (int k = 0; k < 2; k++) begin
      lv = (k == 0) ? 32'(load_val_a) : 32'(load_val_b);
      if (rst) begin
        mv[k] = 0; mw[k] = 1'b0; ml[k] = 1'b0;
      end else begin
        ml[k] = 1'b0;
        if (clr) begin
          mv[k] = 0; mw[k] = 1'b0;
        end else if (load) begin
          mv[k] = load_value(lv, k, e);
          ml[k] = e;
        end else if (en) begin
          if (up) begin
            if (mv[k] == range_p[k] - 1) begin mv[k] = 0; mw[k] = 1'b1; end
            else mv[k] = mv[k] + 1;
          end else begin
            if (mv[k] == 0) begin mv[k] = range_p[k] - 1; mw[k] = 1'b1; end
            else mv[k] = mv[k] - 1;
          end
        end
      end
    end
  endtask

  task automatic model_async_reset();
    for (int k = 0; k < 2; k++) begin
      mv[k] = 0; mw[k] = 1'b0; ml[k] = 1'b0;
    end
  endtask

  // ---------------- driver ----------------
  // Inputs are applied 7 time units after a rising edge; the expected state
  // for the next edge is queued right at that edge.
  task automatic step(input bit s_en, input bit s_up, input bit s_clr, input bit s_load,
                      input logic [7:0] lva, input logic [11:0] lvb);
    logic [31:0] fa;
    logic [31:0] fb;
    en = s_en; up = s_up; clr = s_clr; load = s_load;
    load_val_a = lva; load_val_b = lvb;
    @(posedge clk);
    model_edge();
    fa = to_field(mv[0], 0);
    fb = to_field(mv[1], 1);
    exp_q.push_back({model_tc(1), ml[1], mw[1], fb[11:0], model_tc(0), ml[0], mw[0], fa[7:0]});
    #7;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("count_a",    32'(count_a),    32'(mon_e[7:0]));
      chk("wrap_a",     32'(wrap_a),     32'(mon_e[8]));
      chk("load_err_a", 32'(load_err_a), 32'(mon_e[9]));
      chk("tc_a",       32'(tc_a),       32'(mon_e[10]));
      chk("count_b",    32'(count_b),    32'(mon_e[22:11]));
      chk("wrap_b",     32'(wrap_b),     32'(mon_e[23]));
      chk("load_err_b", 32'(load_err_b), 32'(mon_e[24]));
      chk("tc_b",       32'(tc_b),       32'(mon_e[25]));
      for (int i = 0; i < 2; i++)
        chk("digit_range_a", 32'(count_a[i*4 +: 4] < 4'd10), 32'd1);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int r;
    bit dir_up;
    rst = 1'b1; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0;
    load_val_a = '0; load_val_b = '0;
    model_async_reset();
    #12;
    chk("reset_count_a", 32'(count_a), 32'h0);
    chk("reset_wrap_a", 32'(wrap_a), 32'h0);
    chk("reset_load_err_a", 32'(load_err_a), 32'h0);
    chk("reset_tc_a", 32'(tc_a), 32'h0);
    chk("reset_count_b", 32'(count_b), 32'h0);

    // Reset held with en=1: edges have no effect.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 12'h000);
    chk("rst_held_count_a", 32'(count_a), 32'h0);
    rst = 1'b0;
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 12'h000);
    chk("first_after_rst_a", 32'(count_a), 32'h01);
    chk("first_after_rst_b", 32'(count_b), 32'h001);

    // Mid-count async reset, including a pending load while held.
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h47, 12'h123);
    chk("load_47", 32'(count_a), 32'h47);
    rst = 1'b1;
    #1;
    model_async_reset();
    chk("async_rst_count_a", 32'(count_a), 32'h0);
    chk("async_rst_wrap_a", 32'(wrap_a), 32'h0);
    chk("async_rst_load_err_a", 32'(load_err_a), 32'h0);
    chk("async_rst_count_b", 32'(count_b), 32'h0);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 8'h33, 12'h456);
    chk("rst_discards_load", 32'(count_a), 32'h0);
    rst = 1'b0;
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 12'h000);
    chk("after_mid_rst_a", 32'(count_a), 32'h01);

    // Up wrap on the BCD counter.
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 12'h000);
    for (int i = 0; i < 99; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 12'h000);
    chk("up_99_count", 32'(count_a), 32'h99);
    chk("up_99_tc", 32'(tc_a), 32'h1);
    chk("up_99_wrap", 32'(wrap_a), 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 12'h000);
    chk("up_wrap_count", 32'(count_a), 32'h00);
    chk("up_wrap_flag", 32'(wrap_a), 32'h1);

    // Down counting across a digit borrow, then full down wrap.
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h10, 12'h010);
    chk("load_keeps_wrap", 32'(wrap_a), 32'h1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 12'h000);
    chk("down_09", 32'(count_a), 32'h09);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 12'h000);
    chk("down_08", 32'(count_a), 32'h08);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 12'h000);
    chk("clr_wrap", 32'(wrap_a), 32'h0);
    en = 1'b1; up = 1'b0;
    #1;
    chk("tc_before_down_wrap", 32'(tc_a), 32'h1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 12'h000);
    chk("down_wrap_count", 32'(count_a), 32'h99);
    chk("down_wrap_flag", 32'(wrap_a), 32'h1);

    // Load clamp.
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h3F, 12'h3F0);
    chk("clamp_count", 32'(count_a), 32'h39);
    chk("clamp_load_err", 32'(load_err_a), 32'h1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 12'h000);
    chk("load_err_one_cycle", 32'(load_err_a), 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h42, 12'h042);
    chk("load_42", 32'(count_a), 32'h42);
    chk("load_42_err", 32'(load_err_a), 32'h0);

    // Priority.
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h55, 12'h055);
    chk("pri_pre_wrap", 32'(wrap_a), 32'h1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'h12, 12'h012);
    chk("pri_clr_count", 32'(count_a), 32'h00);
    chk("pri_clr_wrap", 32'(wrap_a), 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'h20, 12'h020);
    chk("pri_load_over_en", 32'(count_a), 32'h20);

    // Hold.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 12'h000);
    chk("hold_count", 32'(count_a), 32'h20);
    chk("hold_tc", 32'(tc_a), 32'h0);

    // Up wrap on the hex 3-digit counter.
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 12'h000);
    for (int i = 0; i < 4095; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 12'h000);
    chk("hex_fff_count", 32'(count_b), 32'hFFF);
    chk("hex_fff_tc", 32'(tc_b), 32'h1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 12'h000);
    chk("hex_wrap_count", 32'(count_b), 32'h000);
    chk("hex_wrap_flag", 32'(wrap_b), 32'h1);

    // Randomized traffic with direction biased in blocks so wraps occur.
    dir_up = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      if (i % 150 == 0) dir_up = ~dir_up;
      r = int'($urandom_range(0, 99));
      step(1'($urandom_range(0, 3) != 0),
           dir_up ? 1'($urandom_range(0, 99) < 85) : 1'($urandom_range(0, 99) < 15),
           1'(r < 2), 1'(r >= 2 && r < 10),
           8'($urandom), 12'($urandom));
    end

    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
    chk("queue_drain", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
